// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer for a registered execute-stage ALU.
//   Accepts one decoded MIPS ALU instruction per in_valid/in_ready handshake,
//   maps opcode/funct to the 4-bit ALU control code and drives the operands,
//   waits out the ALU's result register, then presents the captured result,
//   zero flag, write-back info and exceptions behind out_valid/out_ready.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          instruction handshake
//   opcode, funct, shamt, imm  instruction fields
//   rs_val, rt_val, dest       register operands and write-back index
//   ALUCtrl, SrcA, SrcB, Shmat ALU drive (held between instructions)
//   ALURes, Zero               ALU result, valid one clock after drive
//   out_valid/out_ready        result handshake
//   out_res, out_zero,
//   out_dest, out_wen          captured result and write-back info
//   exc_ovf, exc_ri            signed overflow / reserved instruction,
//                              qualified by out_valid
// Build option:
//   ALU_ISSUE_BYPASS_EN        accept the next instruction during the OUT
//                              handshake and go straight OUT->EXEC
module alu_issue_ctrl #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [5:0]     opcode,
  input  logic [5:0]     funct,
  input  logic [SHW-1:0] shamt,
  input  logic [DW-1:0]  rs_val,
  input  logic [DW-1:0]  rt_val,
  input  logic [15:0]    imm,
  input  logic [4:0]     dest,
  output logic [3:0]     ALUCtrl,
  output logic [DW-1:0]  SrcA,
  output logic [DW-1:0]  SrcB,
  output logic [SHW-1:0] Shmat,
  input  logic [DW-1:0]  ALURes,
  input  logic           Zero,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_res,
  output logic           out_zero,
  output logic [4:0]     out_dest,
  output logic           out_wen,
  output logic           exc_ovf,
  output logic           exc_ri
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, OUT} state_t;
  localparam logic [1:0] CLS_NONE = 2'd0, CLS_ADD = 2'd1, CLS_SUB = 2'd2;
  state_t state, state_n;
  logic [3:0] dec_ctrl;
  logic [DW-1:0] dec_a, dec_b, sext, zext;
  logic [SHW-1:0] dec_sh;
  logic dec_ri;
  logic [1:0] dec_cls, cls_r;
  logic [4:0] dest_r;
  logic ri_r, ovf, ovf_q, ri_q, wen_q, acc;
  assign sext = {{(DW-16){imm[15]}}, imm};
  assign zext = {{(DW-16){1'b0}}, imm};
  always_comb begin
    dec_ctrl = 4'b1101;
    dec_a = rs_val;
    dec_b = rt_val;
    dec_sh = '0;
    dec_ri = 1'b0;
    dec_cls = CLS_NONE;
    if (opcode == 6'h00) begin
      case (funct)
        6'h24: dec_ctrl = 4'b0000;
        6'h25: dec_ctrl = 4'b0001;
        6'h20: begin dec_ctrl = 4'b0010; dec_cls = CLS_ADD; end
        6'h21: dec_ctrl = 4'b0011;
        6'h22: begin dec_ctrl = 4'b0100; dec_cls = CLS_SUB; end
        6'h23: dec_ctrl = 4'b0101;
        6'h2A: dec_ctrl = 4'b0110;
        6'h2B: dec_ctrl = 4'b0111;
        6'h00: begin dec_ctrl = 4'b1000; dec_sh = shamt; end
        6'h02: begin dec_ctrl = 4'b1001; dec_sh = shamt; end
        6'h04: begin dec_ctrl = 4'b1010; dec_a = rt_val; dec_b = {{(DW-SHW){1'b0}}, rs_val[SHW-1:0]}; end
        6'h06: begin dec_ctrl = 4'b1011; dec_a = rt_val; dec_b = {{(DW-SHW){1'b0}}, rs_val[SHW-1:0]}; end
        6'h26: dec_ctrl = 4'b1110;
        6'h27: dec_ctrl = 4'b1111;
        default: dec_ri = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08: begin dec_ctrl = 4'b0010; dec_b = sext; dec_cls = CLS_ADD; end
        6'h09: begin dec_ctrl = 4'b0011; dec_b = sext; end
        6'h0A: begin dec_ctrl = 4'b0110; dec_b = sext; end
        6'h0B: begin dec_ctrl = 4'b0111; dec_b = sext; end
        6'h0C: begin dec_ctrl = 4'b0000; dec_b = zext; end
        6'h0D: begin dec_ctrl = 4'b0001; dec_b = zext; end
        6'h0E: begin dec_ctrl = 4'b1110; dec_b = zext; end
        6'h0F: begin dec_ctrl = 4'b1100; dec_b = zext; end
        default: dec_ri = 1'b1;
      endcase
    end
  end
`ifdef ALU_ISSUE_BYPASS_EN
  // the result slot frees up in the same cycle the consumer takes it
  assign in_ready = (state == IDLE) || (state == OUT && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif
  assign acc = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign out_wen = out_valid && wen_q;
  assign exc_ovf = out_valid && ovf_q;
  assign exc_ri = out_valid && ri_q;
  // overflow from operand signs and the result sign, using the held operands
  assign ovf = (cls_r == CLS_ADD) ? (SrcA[DW-1] == SrcB[DW-1] && ALURes[DW-1] != SrcA[DW-1]) :
               (cls_r == CLS_SUB) ? (SrcA[DW-1] != SrcB[DW-1] && ALURes[DW-1] != SrcA[DW-1]) : 1'b0;
  always_comb begin
    state_n = (state == IDLE) ? (acc ? EXEC : IDLE) :
              (state == EXEC) ? WAIT :
              (state == WAIT) ? OUT :
              (out_ready ? (acc ? EXEC : IDLE) : OUT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ALUCtrl <= '0;
      SrcA <= '0;
      SrcB <= '0;
      Shmat <= '0;
      dest_r <= '0;
      ri_r <= 1'b0;
      cls_r <= CLS_NONE;
      out_res <= '0;
      out_zero <= 1'b0;
      out_dest <= '0;
      ovf_q <= 1'b0;
      ri_q <= 1'b0;
      wen_q <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        ALUCtrl <= dec_ctrl;
        SrcA <= dec_a;
        SrcB <= dec_b;
        Shmat <= dec_sh;
        dest_r <= dest;
        ri_r <= dec_ri;
        cls_r <= dec_cls;
      end
      if (state == WAIT) begin
        out_res <= ALURes;
        out_zero <= Zero;
        out_dest <= dest_r;
        ovf_q <= ovf;
        ri_q <= ri_r;
        wen_q <= !ovf && !ri_r && dest_r != 5'd0;
      end
    end
  end
endmodule
